inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised next-generation instruction queue for the Tomasulo RISC-V core.
- Fetches one instruction per cycle: I-cache hit path, or memctrl miss path with I-cache fill.
- Predecodes JAL and conditional branches; conditional branches are predicted through the BHT.
- Buffers up to DEPTH entries; presents up to ISSUE_W in-order head entries per cycle to the issue stage; supports a flush/redirect from the ROB, including a flush that arrives while a miss is outstanding.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 16, queue entries; must be a power of two, at least 2.
- ISSUE_W, 2, head entries presented per cycle (1..4).
- BHT_IDX_W, 12, BHT index width; the index is pc[BHT_IDX_W+1:2].
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rdy  in  1  global enable; when low, all state holds.
- flush  in  1  ROB mispredict; clear the queue and redirect fetch.
- redirect_pc  in  XLEN  new fetch PC, valid with flush.
- ic_addr  out  XLEN  I-cache lookup address (= fetch pc).
- ic_hit  in  1  combinational hit for ic_addr.
- ic_inst  in  XLEN  instruction on hit.
- ic_fill_valid  out  1  write fill into the I-cache.
- ic_fill_addr  out  XLEN  address of the fill.
- ic_fill_data  out  XLEN  data of the fill.
- mem_req  out  1  one-cycle miss request pulse.
- mem_addr  out  XLEN  address of the miss request.
- mem_ok  in  1  miss data returned.
- mem_data  in  XLEN  returned instruction.
- bht_idx  out  BHT_IDX_W  BHT index of the instruction being enqueued.
- bht_taken  in  1  prediction for bht_idx.
- deq_valid  out  ISSUE_W  deq_valid[k]: head+k is occupied.
- deq_inst  out  ISSUE_W*XLEN  instruction field per slot.
- deq_pc  out  ISSUE_W*XLEN  PC field per slot.
- deq_target  out  ISSUE_W*XLEN  PC field + immediate, per slot.
- deq_taken  out  ISSUE_W  predicted-taken flag per slot.
- deq_num  in  $clog2(ISSUE_W+1)  entries consumed this cycle; must not exceed popcount(deq_valid).
- count  out  $clog2(DEPTH+1)  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset: clk and rst are as decided — reset rst, synchronous, active-high; clock clk. On reset: pc = RESET_PC, head = tail = count = 0, state = FETCH, all entries zeroed. All outputs then read 0, except ic_addr = RESET_PC and empty = 1.
- rdy low: no state changes; mem_req and ic_fill_valid are forced to 0.
- FSM states:
  - FETCH: if the queue is not full and ic_hit, enqueue ic_inst this cycle. If not full and no hit, pulse mem_req with mem_addr = pc and go to MISS.
  - MISS: wait for mem_ok. On mem_ok: ic_fill_valid = 1 with fill addr/data = pc/mem_data, enqueue mem_data (space is guaranteed because only issue drains while waiting), return to FETCH.
  - DROP: entered on flush while in MISS. On mem_ok: discard the data, no enqueue, no fill, go to FETCH.
- Enqueue and next-PC rules:
  - JAL (opcode 6f): taken = 1, target = pc + J-imm, next pc = target.
  - Branch (opcode 63): taken = bht_taken, target = pc + B-imm, next pc = taken ? target : pc + 4.
  - Everything else, including JALR: taken = 0, target = pc + 4, next pc = pc + 4 (JALR always mispredicts and the ROB repairs it).
- bht_idx is driven combinationally from the current pc; bht_taken is sampled in the same cycle.
- Dequeue:
  - deq_* slot k shows entry (head+k) mod DEPTH, combinationally.
  - Each cycle: head += deq_num mod DEPTH; count' = count + enq − deq_num.
  - Simultaneous enqueue and dequeue is legal when full; enqueue is still blocked in that cycle because full is evaluated pre-dequeue.
- Pointers: log2(DEPTH) bits with natural wrap; count is one bit wider, so full and empty are unambiguous.
- Flush (highest priority, overrides same-cycle enq/deq and mem_ok):
  - head = tail = count = 0; pc = redirect_pc.
  - FSM: FETCH→FETCH, MISS→DROP, DROP→DROP.
  - If mem_ok coincides with flush in MISS: data discarded, next state FETCH.
  - No mem_req is issued in the flush cycle.
- mem_req is high for exactly one cycle per miss; at most one miss is outstanding.
- Immediates are sign-extended to XLEN; additions are modulo 2^XLEN.

Decomposition:
- Shared package: XLEN, opcode constants (OP_JAL=7'h6f, OP_BRANCH=7'h63, OP_JALR=7'h67), FSM state encoding (FETCH/MISS/DROP), and the queue entry struct {inst, pc, target, taken}.
- One sub-module: fetch_predecode. Combinational; takes (inst, pc, bht_taken) and produces (is_jal, is_branch, taken, target, next_pc).

Test Plan:
- Hit stream: ic_hit = 1 with ADDI at pc 0,4,8, deq_num = 0 → count reaches 3; deq_pc slots 0/1 = 0/4; pc = 0xC.
- Miss: ic_hit = 0 at pc 0x10 → mem_req pulses once with mem_addr 0x10. mem_ok after 5 cycles with 0x00000013 → fill at 0x10, enqueued, pc = 0x14, state back to FETCH.
- Branch: BEQ at 0x20 with B-imm +16. bht_taken = 1 → deq_taken = 1, target 0x30, next pc 0x30. bht_taken = 0 → pc 0x24, target still 0x30.
- Full and wrap: DEPTH = 4, enqueue 4 → full = 1, no lookup enqueue. Then deq_num = 2 for 3 cycles while hitting → head and tail wrap, deq order matches PC order.
- Flush during miss: in MISS, flush with redirect_pc 0x100 → count = 0, state DROP. mem_ok arrives → no enqueue, no fill. Next cycle ic_addr = 0x100.
- Flush with simultaneous deq_num = 2 and mem_ok → queue empty, state FETCH, pc = redirect_pc.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_pkg
//   Shared definitions for the instruction fetch queue: default data width,
//   RV32 opcodes recognised by the predecoder, fetch FSM state encoding and
//   the queue entry layout {inst, pc, target, taken}.
// ---------------------------------------------------------------------------
package inst_fetch_queue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;

  // Fetch FSM encoding (kept as plain constants for compatibility with
  // older tooling that consumes the state register directly).
  localparam logic [1:0] ST_FETCH = 2'd0;  // look up the I-cache each cycle
  localparam logic [1:0] ST_MISS  = 2'd1;  // waiting for memctrl data
  localparam logic [1:0] ST_DROP  = 2'd2;  // flushed while waiting; discard data

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_predecode.sv
// ---------------------------------------------------------------------------
// fetch_predecode
//   Combinational predecoder for the instruction being enqueued.
//   Ports:
//     inst_i, pc_i    instruction word and its fetch address
//     bht_taken_i     BHT prediction for pc_i
//     is_jal_o        instruction is JAL
//     is_branch_o     instruction is a conditional branch
//     taken_o         predicted-taken flag stored with the entry
//     target_o        pc + immediate (pc + 4 for non-control-flow)
//     next_pc_o       address to fetch next
// ---------------------------------------------------------------------------
module fetch_predecode #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            bht_taken_i,
  output logic            is_jal_o,
  output logic            is_branch_o,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] next_pc_o
);
  import inst_fetch_queue_pkg::*;

  logic [6:0]      opcode;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] seq_pc;

  assign opcode = inst_i[6:0];
  // inst[31] is the sign bit of both immediates and is replicated upward.
  assign j_imm  = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign b_imm  = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign seq_pc = pc_i + XLEN'(4);

  always_comb begin
    is_jal_o    = 1'b0;
    is_branch_o = 1'b0;
    taken_o     = 1'b0;
    target_o    = seq_pc;
    next_pc_o   = seq_pc;
    case (opcode)
      OP_JAL: begin
        is_jal_o  = 1'b1;
        taken_o   = 1'b1;
        target_o  = pc_i + j_imm;
        next_pc_o = pc_i + j_imm;
      end
      OP_BRANCH: begin
        is_branch_o = 1'b1;
        taken_o     = bht_taken_i;
        target_o    = pc_i + b_imm;
        next_pc_o   = bht_taken_i ? (pc_i + b_imm) : seq_pc;
      end
      // JALR target depends on a register value; fetch falls through and
      // the ROB repairs the path on resolution.
      OP_JALR: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//   Fetches one instruction per cycle (I-cache hit, or memctrl miss with an
//   I-cache fill), predecodes JAL/branches for next-PC prediction, buffers up
//   to DEPTH entries and presents ISSUE_W in-order head entries to issue.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     rdy                    global enable; low freezes all state
//     flush, redirect_pc     ROB redirect: empty queue, restart fetch
//     ic_addr/ic_hit/ic_inst I-cache lookup
//     ic_fill_*              I-cache fill on miss return
//     mem_req/mem_addr       one-cycle miss request
//     mem_ok/mem_data        miss data return
//     bht_idx/bht_taken      branch predictor lookup for current pc
//     deq_*                  head slots, deq_num entries consumed per cycle
//     count/full/empty       occupancy
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 16,
  parameter int              ISSUE_W   = 2,
  parameter int              BHT_IDX_W = 12,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rdy,
  input  logic                             flush,
  input  logic [XLEN-1:0]                  redirect_pc,
  output logic [XLEN-1:0]                  ic_addr,
  input  logic                             ic_hit,
  input  logic [XLEN-1:0]                  ic_inst,
  output logic                             ic_fill_valid,
  output logic [XLEN-1:0]                  ic_fill_addr,
  output logic [XLEN-1:0]                  ic_fill_data,
  output logic                             mem_req,
  output logic [XLEN-1:0]                  mem_addr,
  input  logic                             mem_ok,
  input  logic [XLEN-1:0]                  mem_data,
  output logic [BHT_IDX_W-1:0]             bht_idx,
  input  logic                             bht_taken,
  output logic [ISSUE_W-1:0]               deq_valid,
  output logic [ISSUE_W*XLEN-1:0]          deq_inst,
  output logic [ISSUE_W*XLEN-1:0]          deq_pc,
  output logic [ISSUE_W*XLEN-1:0]          deq_target,
  output logic [ISSUE_W-1:0]               deq_taken,
  input  logic [$clog2(ISSUE_W+1)-1:0]     deq_num,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic                             empty
);
  import inst_fetch_queue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] inst_q   [DEPTH];
  logic [XLEN-1:0] epc_q    [DEPTH];
  logic [XLEN-1:0] target_q [DEPTH];
  logic            taken_q  [DEPTH];

  logic            full_w;
  logic            lookup_ok;
  logic            miss_fire;
  logic            fill_fire;
  logic            enq_fire;
  logic [XLEN-1:0] enq_inst;

  logic            pd_is_jal;
  logic            pd_is_branch;
  logic            pd_taken;
  logic [XLEN-1:0] pd_target;
  logic [XLEN-1:0] pd_next_pc;
  logic            pd_class_unused;

  // Full is the pre-dequeue occupancy, so a full queue never enqueues even
  // when issue drains in the same cycle.
  assign full_w    = (count_q == CW'(DEPTH));
  assign lookup_ok = rdy && !flush && (state_q == ST_FETCH) && !full_w;
  assign miss_fire = lookup_ok && !ic_hit;
  // While in MISS only issue drains the queue, so the returning word always
  // has a free slot.
  assign fill_fire = rdy && !flush && (state_q == ST_MISS) && mem_ok;
  assign enq_fire  = (lookup_ok && ic_hit) || fill_fire;
  assign enq_inst  = (state_q == ST_FETCH) ? ic_inst : mem_data;

  fetch_predecode #(.XLEN(XLEN)) u_predecode (
    .inst_i      (enq_inst),
    .pc_i        (pc_q),
    .bht_taken_i (bht_taken),
    .is_jal_o    (pd_is_jal),
    .is_branch_o (pd_is_branch),
    .taken_o     (pd_taken),
    .target_o    (pd_target),
    .next_pc_o   (pd_next_pc)
  );

  // Class flags are already folded into taken/next_pc by the predecoder.
  assign pd_class_unused = pd_is_jal ^ pd_is_branch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = redirect_pc;
      // An outstanding miss must still be absorbed unless it returns in
      // this very cycle.
      if ((state_q == ST_MISS || state_q == ST_DROP) && !mem_ok) state_d = ST_DROP;
      else                                                       state_d = ST_FETCH;
    end else begin
      head_d  = head_q + PW'(deq_num);
      count_d = count_q + CW'(enq_fire) - CW'(deq_num);
      if (enq_fire) begin
        tail_d = tail_q + 1'b1;
        pc_d   = pd_next_pc;
      end
      case (state_q)
        ST_FETCH: if (miss_fire) state_d = ST_MISS;
        ST_MISS,
        ST_DROP:  if (mem_ok)    state_d = ST_FETCH;
        default:                 state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i]   <= '0;
        epc_q[i]    <= '0;
        target_q[i] <= '0;
        taken_q[i]  <= 1'b0;
      end
    end else if (enq_fire) begin
      inst_q[tail_q]   <= enq_inst;
      epc_q[tail_q]    <= pc_q;
      target_q[tail_q] <= pd_target;
      taken_q[tail_q]  <= pd_taken;
    end
  end

  // Head window: slot gi shows entry (head + gi) mod DEPTH.
  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_W; gi++) begin : g_slot
      logic [PW-1:0] slot_idx;
      assign slot_idx                       = head_q + PW'(gi);
      assign deq_valid[gi]                  = (count_q > CW'(gi));
      assign deq_inst[gi*XLEN +: XLEN]      = inst_q[slot_idx];
      assign deq_pc[gi*XLEN +: XLEN]        = epc_q[slot_idx];
      assign deq_target[gi*XLEN +: XLEN]    = target_q[slot_idx];
      assign deq_taken[gi]                  = taken_q[slot_idx];
    end
  endgenerate

  assign ic_addr       = pc_q;
  assign bht_idx       = pc_q[BHT_IDX_W+1:2];
  assign mem_req       = miss_fire;
  assign mem_addr      = miss_fire ? pc_q : '0;
  assign ic_fill_valid = fill_fire;
  assign ic_fill_addr  = fill_fire ? pc_q : '0;
  assign ic_fill_data  = fill_fire ? mem_data : '0;
  assign count         = count_q;
  assign full          = full_w;
  assign empty         = (count_q == '0);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Scoreboard bench: each enqueue the reference model predicts pushes an
//   expected entry; each dequeue pops and compares the head slots.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int TXLEN   = 32;
  localparam int DEPTH   = 4;
  localparam int ISSUE_W = 2;
  localparam int BW      = 12;
  localparam int CW      = $clog2(DEPTH+1);
  localparam int DW      = $clog2(ISSUE_W+1);

  logic                     clk;
  logic                     rst;
  logic                     rdy;
  logic                     flush;
  logic [TXLEN-1:0]         redirect_pc;
  logic [TXLEN-1:0]         ic_addr;
  logic                     ic_hit;
  logic [TXLEN-1:0]         ic_inst;
  logic                     ic_fill_valid;
  logic [TXLEN-1:0]         ic_fill_addr;
  logic [TXLEN-1:0]         ic_fill_data;
  logic                     mem_req;
  logic [TXLEN-1:0]         mem_addr;
  logic                     mem_ok;
  logic [TXLEN-1:0]         mem_data;
  logic [BW-1:0]            bht_idx;
  logic                     bht_taken;
  logic [ISSUE_W-1:0]       deq_valid;
  logic [ISSUE_W*TXLEN-1:0] deq_inst;
  logic [ISSUE_W*TXLEN-1:0] deq_pc;
  logic [ISSUE_W*TXLEN-1:0] deq_target;
  logic [ISSUE_W-1:0]       deq_taken;
  logic [DW-1:0]            deq_num;
  logic [CW-1:0]            count;
  logic                     full;
  logic                     empty;

  logic                     hit_en;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  int          m_state;   // 0 fetch, 1 miss, 2 drop
  ifq_entry_t  sb[$];

  inst_fetch_queue #(
    .XLEN(TXLEN), .DEPTH(DEPTH), .ISSUE_W(ISSUE_W), .BHT_IDX_W(BW), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .redirect_pc(redirect_pc),
    .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_inst(ic_inst),
    .ic_fill_valid(ic_fill_valid), .ic_fill_addr(ic_fill_addr), .ic_fill_data(ic_fill_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ok(mem_ok), .mem_data(mem_data),
    .bht_idx(bht_idx), .bht_taken(bht_taken),
    .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc(deq_pc),
    .deq_target(deq_target), .deq_taken(deq_taken), .deq_num(deq_num),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: ADDI x1,x1,<addr-derived imm> everywhere except a JALR
  // at 0x18, BEQ +16 at 0x20 and JAL -16 at 0x44.
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    case (a)
      32'h18:  return 32'h00008067;
      32'h20:  return 32'h00000863;
      32'h44:  return 32'hFF1FF06F;
      default: return {a[13:2], 5'd1, 3'b000, 5'd1, 7'h13};
    endcase
  endfunction

  assign ic_hit  = hit_en;
  assign ic_inst = inst_at(ic_addr);

  function automatic ifq_entry_t model_pd(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic bt, output logic [31:0] npc);
    ifq_entry_t e;
    logic signed [20:0] j;
    logic signed [12:0] b;
    int imm;
    j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    e.inst   = ins;
    e.pc     = pc;
    e.taken  = 1'b0;
    e.target = pc + 32'd4;
    npc      = pc + 32'd4;
    if (ins[6:0] == 7'b1101111) begin
      imm = int'(j);
      e.target = pc + imm;
      e.taken  = 1'b1;
      npc      = e.target;
    end else if (ins[6:0] == 7'b1100011) begin
      imm = int'(b);
      e.target = pc + imm;
      e.taken  = bt;
      if (bt) npc = e.target;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: caller has set the other inputs at the falling edge.
  task automatic cycle(input int want_deq);
    int          nd;
    logic        exp_enq, exp_req, exp_fill;
    logic [31:0] ins, npc;
    ifq_entry_t  e;
    nd = (want_deq > sb.size()) ? sb.size() : want_deq;
    if (nd > ISSUE_W) nd = ISSUE_W;
    deq_num = DW'(nd);
    #1;
    chk("ic_addr", ic_addr, m_pc);
    chk("bht_idx", bht_idx, m_pc[13:2]);
    chk("count", count, sb.size());
    chk("full", full, sb.size() == DEPTH);
    chk("empty", empty, sb.size() == 0);
    for (int k = 0; k < ISSUE_W; k++) begin
      chk("deq_valid", deq_valid[k], sb.size() > k);
      if (k < nd) begin
        chk("deq_pc",     deq_pc[k*32 +: 32],     sb[k].pc);
        chk("deq_inst",   deq_inst[k*32 +: 32],   sb[k].inst);
        chk("deq_target", deq_target[k*32 +: 32], sb[k].target);
        chk("deq_taken",  deq_taken[k],           sb[k].taken);
      end
    end
    exp_enq = 1'b0; exp_req = 1'b0; exp_fill = 1'b0; ins = '0;
    if (rdy && !flush) begin
      if (m_state == 0 && sb.size() < DEPTH) begin
        if (hit_en) begin exp_enq = 1'b1; ins = inst_at(m_pc); end
        else exp_req = 1'b1;
      end else if (m_state == 1 && mem_ok) begin
        exp_enq = 1'b1; exp_fill = 1'b1; ins = mem_data;
      end
    end
    chk("mem_req", mem_req, exp_req);
    if (exp_req) chk("mem_addr", mem_addr, m_pc);
    chk("fill_valid", ic_fill_valid, exp_fill);
    if (exp_fill) begin
      chk("fill_addr", ic_fill_addr, m_pc);
      chk("fill_data", ic_fill_data, mem_data);
    end
    if (rdy) begin
      if (flush) begin
        sb.delete();
        m_pc    = redirect_pc;
        m_state = (m_state != 0 && !mem_ok) ? 2 : 0;
      end else begin
        for (int k = 0; k < nd; k++) void'(sb.pop_front());
        if (exp_enq) begin
          e = model_pd(ins, m_pc, bht_taken, npc);
          sb.push_back(e);
          m_pc = npc;
        end
        if (exp_req) m_state = 1;
        else if (m_state != 0 && mem_ok) m_state = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle_fetch();
    rdy = 1'b1; flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_ok = (m_state != 0);
      if (m_state != 0) cycle(0);
    end
    mem_ok = 1'b0;
    chk("settle_state", m_state, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; redirect_pc = '0; hit_en = 1'b1;
    mem_ok = 1'b0; mem_data = '0; bht_taken = 1'b0; deq_num = '0;
    m_pc = 32'h0; m_state = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ic_addr", ic_addr, 32'h0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_deq_taken", deq_taken, 0);
    chk("rst_deq_inst", deq_inst, 0);
    chk("rst_deq_pc", deq_pc, 0);
    chk("rst_deq_target", deq_target, 0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_fill", ic_fill_valid, 1'b0);

    // Hit stream at 0, 4, 8 without dequeue.
    repeat (3) cycle(0);
    chk("hs_count", count, 3);
    chk("hs_slot0_pc", deq_pc[31:0], 32'h0);
    chk("hs_slot1_pc", deq_pc[63:32], 32'h4);
    chk("hs_pc", ic_addr, 32'hC);

    // Drain while fetching 0xC, then miss at 0x10.
    cycle(2);
    hit_en = 1'b0;
    cycle(2);
    chk("miss_state", m_state, 1);
    repeat (4) cycle(0);
    mem_ok = 1'b1; mem_data = 32'h00000013;
    cycle(0);
    mem_ok = 1'b0; hit_en = 1'b1;
    chk("miss_pc", ic_addr, 32'h14);
    chk("miss_count", count, 1);

    // Through JALR at 0x18 and a taken BEQ at 0x20.
    bht_taken = 1'b1;
    repeat (4) cycle(1);
    chk("beq_taken_pc", ic_addr, 32'h30);
    repeat (6) cycle(1);

    // Redirect to the BEQ and predict not taken.
    flush = 1'b1; redirect_pc = 32'h20; bht_taken = 1'b0;
    cycle(1);
    flush = 1'b0;
    cycle(0);
    chk("beq_nt_pc", ic_addr, 32'h24);
    chk("beq_nt_target", deq_target[31:0], 32'h30);
    chk("beq_nt_taken", deq_taken[0], 1'b0);

    // Fill to full, hold, then drain two per cycle across the wrap.
    repeat (5) cycle(0);
    chk("full_flag", full, 1'b1);
    repeat (3) cycle(2);
    repeat (4) cycle(2);

    // Randomised traffic including rdy stalls, misses and flushes.
    for (int n = 0; n < 400; n++) begin
      rdy       = ($urandom_range(0, 7) != 0);
      hit_en    = ($urandom_range(0, 3) != 0);
      bht_taken = $urandom_range(0, 1) == 1;
      flush     = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'h20;
        1:       redirect_pc = 32'h44;
        2:       redirect_pc = 32'h18;
        default: redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      mem_ok   = (m_state != 0) && ($urandom_range(0, 2) == 0);
      mem_data = inst_at(m_pc);
      cycle($urandom_range(0, 2));
    end
    flush = 1'b0; rdy = 1'b1; bht_taken = 1'b0;
    settle_fetch();

    // Flush while a miss is outstanding.
    flush = 1'b1; redirect_pc = 32'h60; hit_en = 1'b0;
    cycle(0);
    flush = 1'b0;
    cycle(0);
    chk("drop_miss_state", m_state, 1);
    repeat (2) cycle(0);
    flush = 1'b1; redirect_pc = 32'h100;
    cycle(0);
    flush = 1'b0;
    chk("drop_count", count, 0);
    chk("drop_state", m_state, 2);
    mem_ok = 1'b1; mem_data = 32'h00000013;
    cycle(0);
    mem_ok = 1'b0; hit_en = 1'b1;
    chk("drop_after_count", count, 0);
    chk("drop_after_pc", ic_addr, 32'h100);
    cycle(0);

    // Flush coinciding with deq_num = 2 and mem_ok in MISS.
    cycle(0);
    hit_en = 1'b0;
    cycle(0);
    chk("fx_count", count, 2);
    cycle(0);
    flush = 1'b1; redirect_pc = 32'h200; mem_ok = 1'b1; mem_data = 32'h00000013;
    cycle(2);
    flush = 1'b0; mem_ok = 1'b0;
    chk("fx_empty", empty, 1'b1);
    chk("fx_pc", ic_addr, 32'h200);
    cycle(0);
    chk("fx_refetch_state", m_state, 1);
    mem_ok = 1'b1;
    mem_data = inst_at(32'h200);
    cycle(0);
    mem_ok = 1'b0; hit_en = 1'b1;
    cycle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
